game_board: RTL and testbench

GAME_BOARD -- requirements
Module: game_board

---
 rtl/tictactoe_pkg.sv | 65 ++++++
 rtl/game_board_if.sv | 21 ++
 rtl/flop.sv | 20 ++
 rtl/line_match.sv | 15 +
 rtl/mux2.sv | 11 +
 rtl/game_board.sv | 115 +++++++++++
 tb/tb_game_board.sv | 226 ++++++++++++++++++++++
 7 files changed

// File: rtl/tictactoe_pkg.sv
// Shared tic-tac-toe definitions: cell/winner codes, board FSM states,
// the line scan table and small board helpers.
package tictactoe_pkg;

    localparam int unsigned CELL_W  = 2;
    localparam int unsigned NCELLS  = 9;
    localparam int unsigned NLINES  = 8;
    localparam int unsigned BOARD_W = CELL_W * NCELLS;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CNT_W   = 3;

    localparam logic [CELL_W-1:0] CELL_EMPTY = 2'b00;
    localparam logic [CELL_W-1:0] CELL_P1    = 2'b11;
    localparam logic [CELL_W-1:0] CELL_P2    = 2'b10;

    localparam logic [CELL_W-1:0] WIN_NONE   = 2'b00;
    localparam logic [CELL_W-1:0] WIN_TIE    = 2'b01;

    // IDLE must encode as zero: the register reset value is all-zero.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } gb_state_e;

    // Line k occupies bits [12k+11:12k]; cell j of that line is nibble j.
    // Order: rows, columns, diagonals {0,4,8} then {2,4,6}.
    localparam logic [95:0] LINE_TABLE = {
        12'h642, 12'h840,                     // diagonals (line 7, 6)
        12'h852, 12'h741, 12'h630,            // columns   (line 5, 4, 3)
        12'h876, 12'h543, 12'h210             // rows      (line 2, 1, 0)
    };

    // All architectural state in one vector so a single reset mux covers it.
    typedef struct packed {
        gb_state_e            state;
        logic [BOARD_W-1:0]   board;
        logic [CNT_W-1:0]     cnt;
        logic                 ack;
        logic                 err;
        logic [CELL_W-1:0]    winner;
    } gb_regs_t;

    function automatic logic [IDX_W-1:0] line_cell(input logic [CNT_W-1:0] k,
                                                   input logic [1:0]       j);
        return LINE_TABLE[7'(32'(k) * 12 + 32'(j) * 4) +: IDX_W];
    endfunction

    // Out-of-range indices read as empty so callers never select past the board.
    function automatic logic [CELL_W-1:0] cell_at(input logic [BOARD_W-1:0] board,
                                                  input logic [IDX_W-1:0]   idx);
        if (idx > IDX_W'(NCELLS - 1)) return CELL_EMPTY;
        return board[5'(32'(idx) * CELL_W) +: CELL_W];
    endfunction

    function automatic logic board_full(input logic [BOARD_W-1:0] board);
        logic full;
        full = 1'b1;
        for (int i = 0; i < int'(NCELLS); i++) begin
            if (board[5'(i * int'(CELL_W)) +: CELL_W] == CELL_EMPTY) full = 1'b0;
        end
        return full;
    endfunction

endpackage

// File: rtl/game_board_if.sv
// Move request channel: valid/cell/player in, ready/ack/err back.
interface game_board_if;
    import tictactoe_pkg::*;

    logic                 move_valid;
    logic [IDX_W-1:0]     move_cell;
    logic [CELL_W-1:0]    move_player;
    logic                 move_ready;
    logic                 move_ack;
    logic                 move_err;

    modport master (
        output move_valid, move_cell, move_player,
        input  move_ready, move_ack, move_err
    );

    modport slave (
        input  move_valid, move_cell, move_player,
        output move_ready, move_ack, move_err
    );
endinterface

// File: rtl/flop.sv
// Two-phase master/slave flop: master follows d while ph2 is high, slave
// follows the master while ph1 is high. Ports: ph1, ph2, d, q.
module flop #(
    parameter int unsigned W = 1
) (
    input  logic         ph1,
    input  logic         ph2,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] mid;

    always_latch begin
        if (ph2) mid <= d;
    end

    always_latch begin
        if (ph1) q <= mid;
    end
endmodule

// File: rtl/line_match.sv
// Combinational three-in-a-row detector.
// Ports: a/b/c cell codes in; match when all equal and non-empty; code = the
// shared cell code on a match, empty otherwise.
module line_match
    import tictactoe_pkg::*;
(
    input  logic [CELL_W-1:0] a,
    input  logic [CELL_W-1:0] b,
    input  logic [CELL_W-1:0] c,
    output logic              match,
    output logic [CELL_W-1:0] code
);
    assign match = (a != CELL_EMPTY) && (a == b) && (b == c);
    assign code  = match ? a : CELL_EMPTY;
endmodule

// File: rtl/mux2.sv
// Two-input mux. Ports: d0/d1 data, s select (1 picks d1), y result.
module mux2 #(
    parameter int unsigned W = 1
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic         s,
    output logic [W-1:0] y
);
    assign y = s ? d1 : d0;
endmodule

// File: rtl/game_board.sv
// Tic-tac-toe board: accepts moves in IDLE, then scans the eight lines one per
// cycle in CHECK and latches a win or tie into DONE.
// Ports: ph1/ph2 clock phases, reset (sync, active-high), mv move channel,
// gBoard packed board, gameIsDone, winner code.
module game_board
    import tictactoe_pkg::*;
(
    input  logic               ph1,
    input  logic               ph2,
    input  logic               reset,
    game_board_if.slave        mv,
    output logic [BOARD_W-1:0] gBoard,
    output logic               gameIsDone,
    output logic [CELL_W-1:0]  winner
);
    localparam int unsigned REGS_W = $bits(gb_regs_t);

    gb_regs_t          regs_q;
    gb_regs_t          regs_d;
    logic [REGS_W-1:0] regs_mux;
    logic [REGS_W-1:0] regs_vec;

    logic              lm_match;
    logic [CELL_W-1:0] lm_code;
    logic              reject;

    // State register: reset forces the all-zero value through the mux.
    mux2 #(.W(REGS_W)) u_rst_mux (
        .d0 (regs_d),
        .d1 ({REGS_W{1'b0}}),
        .s  (reset),
        .y  (regs_mux)
    );

    flop #(.W(REGS_W)) u_regs (
        .ph1 (ph1),
        .ph2 (ph2),
        .d   (regs_mux),
        .q   (regs_vec)
    );

    assign regs_q = gb_regs_t'(regs_vec);

    // Line under test this cycle, selected by the scan counter.
    line_match u_line_match (
        .a     (cell_at(regs_q.board, line_cell(regs_q.cnt, 2'd0))),
        .b     (cell_at(regs_q.board, line_cell(regs_q.cnt, 2'd1))),
        .c     (cell_at(regs_q.board, line_cell(regs_q.cnt, 2'd2))),
        .match (lm_match),
        .code  (lm_code)
    );

    assign reject = (mv.move_cell > IDX_W'(NCELLS - 1))
                 || !((mv.move_player == CELL_P1) || (mv.move_player == CELL_P2))
                 || (cell_at(regs_q.board, mv.move_cell) != CELL_EMPTY);

    // Next-state logic.
    always_comb begin
        regs_d     = regs_q;
        regs_d.ack = 1'b0;
        regs_d.err = 1'b0;

        case (regs_q.state)
            ST_IDLE: begin
                if (mv.move_valid) begin
                    if (reject) begin
                        regs_d.err = 1'b1;
                    end else begin
                        for (int i = 0; i < int'(NCELLS); i++) begin
                            if (mv.move_cell == IDX_W'(i))
                                regs_d.board[5'(i * int'(CELL_W)) +: CELL_W] = mv.move_player;
                        end
                        regs_d.ack   = 1'b1;
                        regs_d.cnt   = '0;
                        regs_d.state = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                if (lm_match) begin
                    regs_d.winner = lm_code;
                    regs_d.state  = ST_DONE;
                end else if (regs_q.cnt == CNT_W'(NLINES - 1)) begin
                    regs_d.cnt = '0;
                    // A win anywhere would have matched above, so full here means tie.
                    if (board_full(regs_q.board)) begin
                        regs_d.winner = WIN_TIE;
                        regs_d.state  = ST_DONE;
                    end else begin
                        regs_d.state  = ST_IDLE;
                    end
                end else begin
                    regs_d.cnt = regs_q.cnt + CNT_W'(1);
                end
            end

            ST_DONE: begin
                regs_d.state = ST_DONE;
            end

            default: begin
                regs_d.state = ST_IDLE;
            end
        endcase
    end

    assign mv.move_ready = (regs_q.state == ST_IDLE);
    assign mv.move_ack   = regs_q.ack;
    assign mv.move_err   = regs_q.err;
    assign gBoard        = regs_q.board;
    assign winner        = regs_q.winner;
    assign gameIsDone    = (regs_q.state == ST_DONE);

endmodule

// File: tb/tb_game_board.sv
// Directed bench for game_board: drives inputs and samples outputs on the
// falling edge of ph1, one clock cycle per ph1 period.
module tb_game_board;
    import tictactoe_pkg::*;

    logic        ph1;
    logic        ph2;
    logic        reset;
    logic [17:0] gboard;
    logic        done;
    logic [1:0]  winner;
    int          checks;
    int          errors;
    int          lat;

    game_board_if bus();

    game_board dut (
        .ph1        (ph1),
        .ph2        (ph2),
        .reset      (reset),
        .mv         (bus),
        .gBoard     (gboard),
        .gameIsDone (done),
        .winner     (winner)
    );

    // Non-overlapping phases, 20-unit period.
    initial begin
        ph1 = 1'b0;
        ph2 = 1'b0;
        forever begin
            #1 ph1 = 1'b1;
            #8 ph1 = 1'b0;
            #2 ph2 = 1'b1;
            #8 ph2 = 1'b0;
            #1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge ph1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.move_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Present a move for one cycle; returns in cycle N+1.
    task automatic do_move(input logic [3:0] c, input logic [1:0] p);
        bus.move_valid  = 1'b1;
        bus.move_cell   = c;
        bus.move_player = p;
        tick();
        bus.move_valid  = 1'b0;
    endtask

    // From cycle N+1, wait (bounded) until ready; lat ends as cycles since N.
    task automatic wait_idle(output int l);
        l = 1;
        while (!bus.move_ready && l < 30) begin
            tick();
            l++;
        end
    endtask

    // Non-final move: expect ack and a full 8-line scan back to IDLE.
    task automatic move_settle(input string tag, input logic [3:0] c, input logic [1:0] p);
        int l;
        do_move(c, p);
        check({tag, "_ack"}, 32'(bus.move_ack), 32'd1);
        wait_idle(l);
        check({tag, "_lat"}, 32'(l), 32'd9);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.move_valid  = 1'b0;
        bus.move_cell   = 4'd0;
        bus.move_player = 2'b00;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check("rst_board",  32'(gboard), 32'h0);
        check("rst_winner", 32'(winner), 32'h0);
        check("rst_done",   32'(done), 32'h0);
        check("rst_ackerr", 32'({bus.move_ack, bus.move_err}), 32'h0);
        reset = 1'b0;
        tick();
        check("rst_ready",  32'(bus.move_ready), 32'h1);

        // First move, centre cell
        do_move(4'd4, 2'b11);
        check("m1_ack",   32'(bus.move_ack), 32'h1);
        check("m1_err",   32'(bus.move_err), 32'h0);
        check("m1_board", 32'(gboard), 32'h00300);
        check("m1_ready", 32'(bus.move_ready), 32'h0);
        tick();
        check("m1_ack_pulse", 32'(bus.move_ack), 32'h0);
        repeat (6) tick();
        check("m1_ready_n8", 32'(bus.move_ready), 32'h0);
        tick();
        check("m1_ready_n9", 32'(bus.move_ready), 32'h1);
        check("m1_winner",   32'(winner), 32'h0);

        // Rejections
        do_move(4'd4, 2'b10);
        check("occ_err",   32'(bus.move_err), 32'h1);
        check("occ_ack",   32'(bus.move_ack), 32'h0);
        check("occ_ready", 32'(bus.move_ready), 32'h1);
        check("occ_board", 32'(gboard), 32'h00300);
        tick();
        check("occ_err_pulse", 32'(bus.move_err), 32'h0);
        do_move(4'd9, 2'b11);
        check("cell9_err", 32'(bus.move_err), 32'h1);
        do_move(4'd0, 2'b01);
        check("p01_err",   32'(bus.move_err), 32'h1);
        check("p01_board", 32'(gboard), 32'h00300);

        // Player1 wins row 0
        do_reset();
        move_settle("w_a", 4'd0, 2'b11);
        move_settle("w_b", 4'd3, 2'b10);
        move_settle("w_c", 4'd1, 2'b11);
        move_settle("w_d", 4'd4, 2'b10);
        do_move(4'd2, 2'b11);
        check("win_ack",     32'(bus.move_ack), 32'h1);
        check("win_done_n1", 32'(done), 32'h0);
        tick();
        check("win_winner",  32'(winner), 32'h3);
        check("win_done",    32'(done), 32'h1);
        check("win_ready",   32'(bus.move_ready), 32'h0);
        check("win_board",   32'(gboard), 32'h002BF);
        do_move(4'd8, 2'b11);
        check("win_ignore",  32'({bus.move_ack, bus.move_err}), 32'h0);
        check("win_board2",  32'(gboard), 32'h002BF);

        // Tie
        do_reset();
        move_settle("t0", 4'd0, 2'b11);
        move_settle("t1", 4'd1, 2'b10);
        move_settle("t2", 4'd2, 2'b11);
        move_settle("t3", 4'd3, 2'b11);
        move_settle("t4", 4'd4, 2'b10);
        move_settle("t5", 4'd5, 2'b10);
        move_settle("t6", 4'd6, 2'b10);
        move_settle("t7", 4'd7, 2'b11);
        do_move(4'd8, 2'b11);
        check("tie_ack", 32'(bus.move_ack), 32'h1);
        repeat (7) tick();
        check("tie_done_n8", 32'(done), 32'h0);
        tick();
        check("tie_done",   32'(done), 32'h1);
        check("tie_winner", 32'(winner), 32'h1);
        check("tie_board",  32'(gboard), 32'h3EAFB);
        do_move(4'd0, 2'b10);
        check("tie_ignore", 32'({bus.move_ack, bus.move_err}), 32'h0);

        // Reset during a scan
        do_reset();
        do_move(4'd0, 2'b11);
        check("mid_ack", 32'(bus.move_ack), 32'h1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("mid_board",  32'(gboard), 32'h0);
        check("mid_ready",  32'(bus.move_ready), 32'h1);
        check("mid_ackerr", 32'({bus.move_ack, bus.move_err}), 32'h0);
        reset = 1'b0;
        repeat (8) tick();
        check("mid_winner", 32'(winner), 32'h0);
        check("mid_done",   32'(done), 32'h0);
        check("mid_idle",   32'(bus.move_ready), 32'h1);

        // Player2 diagonal {2,4,6}, valid held high during the scan
        do_reset();
        move_settle("d0", 4'd2, 2'b10);
        move_settle("d1", 4'd0, 2'b11);
        move_settle("d2", 4'd4, 2'b10);
        move_settle("d3", 4'd1, 2'b11);
        bus.move_valid  = 1'b1;
        bus.move_cell   = 4'd6;
        bus.move_player = 2'b10;
        tick();
        check("diag_ack", 32'(bus.move_ack), 32'h1);
        bus.move_cell   = 4'd8;
        bus.move_player = 2'b11;
        for (int c = 2; c <= 8; c++) begin
            tick();
            check("diag_hold", 32'({bus.move_ack, bus.move_err}), 32'h0);
        end
        check("diag_winner_n8", 32'(winner), 32'h0);
        tick();
        bus.move_valid = 1'b0;
        check("diag_winner", 32'(winner), 32'h2);
        check("diag_done",   32'(done), 32'h1);
        check("diag_board",  32'(gboard), 32'h0222F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
